// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_unit
// Description : Data-hazard controller for an RV32I five-stage pipeline.
//               It produces per-source forwarding selects, inserts a
//               load-use bubble, and freezes the pipe while a load in MEM
//               waits for memory. A sticky watchdog flags long memory waits.
//               Optional feature macro: HAZARD_PERF_EN (stall / load-use
//               performance counters).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_unit #(
  parameter int NUM_SRC  = 2,
  parameter int RAW      = 5,
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 200
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SRC*RAW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]     id_rs_used,
  input  logic                   id_valid,
  input  logic                   flush,
  input  logic [RAW-1:0]         ex_rd,
  input  logic [RAW-1:0]         mem_rd,
  input  logic [RAW-1:0]         wb_rd,
  input  logic                   ex_valid,
  input  logic                   mem_valid,
  input  logic                   wb_valid,
  input  logic                   ex_wen,
  input  logic                   mem_wen,
  input  logic                   wb_wen,
  input  logic                   ex_mem_ren,
  input  logic                   mem_mem_ren,
  input  logic                   mem_rdy,
  output logic [NUM_SRC*3-1:0]   src_sel,
  output logic                   stall_if,
  output logic                   stall_id,
  output logic                   bubble_ex,
  output logic                   stall_ex,
  output logic                   stall_mem,
  output logic                   bubble_wb,
  output logic                   wait_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]            perf_stall_cyc,
  output logic [31:0]            perf_lu_cnt
`endif
);

  localparam logic [WAIT_W-1:0] C_MAX_WAIT = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LU    = 2'd1,
    ST_MWAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              wait_timeout_q, wait_timeout_d;

  logic [NUM_SRC-1:0] w_ex_hit;
  logic [NUM_SRC-1:0] w_mem_hit;
  logic [NUM_SRC-1:0] w_wb_hit;
  logic               w_lu_hit;
  logic               w_mem_busy;

  // Per-source producer matching and forwarding select (EX > MEM > WB > RF)
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [RAW-1:0] w_rs;
    logic           w_rs_live;
    logic [2:0]     w_sel;

    assign w_rs      = id_rs[gi*RAW +: RAW];
    // x0 never forwards: a nonzero source is enough since rd must equal it
    assign w_rs_live = id_rs_used[gi] & (w_rs != '0);

    assign w_ex_hit[gi]  = w_rs_live & ex_valid  & ex_wen  & (ex_rd  == w_rs);
    assign w_mem_hit[gi] = w_rs_live & mem_valid & mem_wen & (mem_rd == w_rs);
    assign w_wb_hit[gi]  = w_rs_live & wb_valid  & wb_wen  & (wb_rd  == w_rs);

    // Select the youngest producer of this source operand
    always_comb begin
      w_sel = 3'b000;
      if (w_ex_hit[gi]) begin
        w_sel = 3'b001;
      end else if (w_mem_hit[gi]) begin
        w_sel = mem_mem_ren ? 3'b011 : 3'b010;
      end else if (w_wb_hit[gi]) begin
        w_sel = 3'b100;
      end
    end

    assign src_sel[gi*3 +: 3] = w_sel;
  end

  assign w_lu_hit   = id_valid & ~flush & ex_mem_ren & (|w_ex_hit);
  assign w_mem_busy = mem_valid & mem_mem_ren & ~mem_rdy;

  // Next-state and stall/bubble outputs; state only suppresses a re-stall
  always_comb begin
    state_d   = state_q;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    bubble_wb = 1'b0;

    if (w_mem_busy) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      bubble_wb = 1'b1;
    end else if (w_lu_hit && (state_q != ST_LU)) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (w_mem_busy)    state_d = ST_MWAIT;
        else if (w_lu_hit) state_d = ST_LU;
        else               state_d = ST_RUN;
      end
      ST_LU: begin
        // The load has moved to MEM, so the same instruction is not re-stalled
        if (w_mem_busy) state_d = ST_MWAIT;
        else            state_d = ST_RUN;
      end
      ST_MWAIT: begin
        if (!w_mem_busy) state_d = w_lu_hit ? ST_LU : ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Wait counter saturates at the bound; timeout is sticky until reset
  always_comb begin
    wait_cnt_d     = '0;
    wait_timeout_d = wait_timeout_q;
    if (w_mem_busy) begin
      if (wait_cnt_q != C_MAX_WAIT) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      else                          wait_cnt_d = wait_cnt_q;
      if (wait_cnt_d == C_MAX_WAIT) wait_timeout_d = 1'b1;
    end
  end

  // State, wait counter and watchdog registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= '0;
      wait_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      wait_timeout_q <= wait_timeout_d;
    end
  end

  assign wait_timeout = wait_timeout_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cyc_q, perf_stall_cyc_d;
  logic [31:0] perf_lu_cnt_q, perf_lu_cnt_d;

  // Count stalled fetch cycles and entries into the load-use state
  always_comb begin
    perf_stall_cyc_d = perf_stall_cyc_q;
    perf_lu_cnt_d    = perf_lu_cnt_q;
    if (stall_if) perf_stall_cyc_d = perf_stall_cyc_q + 32'd1;
    if ((state_d == ST_LU) && (state_q != ST_LU)) perf_lu_cnt_d = perf_lu_cnt_q + 32'd1;
  end

  // Performance counter registers, wrapping naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cyc_q <= '0;
      perf_lu_cnt_q    <= '0;
    end else begin
      perf_stall_cyc_q <= perf_stall_cyc_d;
      perf_lu_cnt_q    <= perf_lu_cnt_d;
    end
  end

  assign perf_stall_cyc = perf_stall_cyc_q;
  assign perf_lu_cnt    = perf_lu_cnt_q;
`endif

endmodule
`default_nettype wire
